// File: rtl/arb_xfer_ctrl.sv
// arb_xfer_ctrl
// -------------
// Transfer controller that sits directly downstream of an N-bit
// fixed-priority arbiter. It captures the winning requester from a one-hot
// grant and streams that requester's burst to one shared valid/ready output
// port. At the end of the burst it pulses a per-requester done flag. Grants
// that arrive while a burst is in flight are ignored.
//
// Ports
//   i_clk    : sole clock, rising edge
//   i_rst    : synchronous, active-high reset
//   i_grant  : one-hot grant from the arbiter, bit k = requester k
//   i_data   : packed beat data, requester k at [k*DATA_W +: DATA_W]
//   i_len    : packed burst length, requester k at [k*LEN_W +: LEN_W]
//              (burst = len + 1 beats)
//   i_ready  : downstream sink accepts the current beat
//   o_data   : current beat of the owner, zero when o_valid is low
//   o_valid  : beat valid
//   o_owner  : index of the current / last captured owner
//   o_busy   : burst in flight (XFER or DONE)
//   o_done   : one-cycle pulse on the bit of the finishing owner
//   o_err    : one-cycle pulse, grant had more than one bit set in IDLE
module arb_xfer_ctrl #(
  parameter  int N      = 8,
  parameter  int DATA_W = 8,
  parameter  int LEN_W  = 4,
  localparam int OW     = $clog2(N)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N-1:0]        i_grant,
  input  logic [N*DATA_W-1:0] i_data,
  input  logic [N*LEN_W-1:0]  i_len,
  input  logic                i_ready,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_valid,
  output logic [OW-1:0]       o_owner,
  output logic                o_busy,
  output logic [N-1:0]        o_done,
  output logic                o_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [N-1:0] GRANT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [LEN_W-1:0] cnt_q,   cnt_d;
  logic             err_q,   err_d;

  logic [N-1:0]     grant_m1;
  logic             grant_one_hot;
  logic             grant_multi;
  logic [OW-1:0]    grant_idx;
  logic [LEN_W-1:0] grant_len;

  // Grant decode. Clearing the lowest set bit (g & (g-1)) leaves zero only
  // for a one-hot or all-zero vector, which separates the legal capture case
  // from the multi-bit error case without a population count.
  always_comb begin
    grant_m1      = i_grant - GRANT_ONE;
    grant_one_hot = (i_grant != '0) && ((i_grant & grant_m1) == '0);
    grant_multi   = (i_grant != '0) && !grant_one_hot;
    grant_idx     = '0;
    for (int k = 0; k < N; k++) begin
      if (i_grant[k]) begin
        grant_idx = OW'(k);
      end
    end
    grant_len = i_len[grant_idx*LEN_W +: LEN_W];
  end

  // Next-state logic. The counter holds the number of beats still to send
  // after the current one, so reaching zero on an accepted beat ends the
  // burst and a full-range length never wraps.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_one_hot) begin
          owner_d = grant_idx;
          cnt_d   = grant_len;
          state_d = S_XFER;
        end else if (grant_multi) begin
          err_d = 1'b1;
        end
      end
      S_XFER: begin
        if (i_ready) begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any burst without a done pulse because
  // o_done is decoded from the DONE state only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Output decode. o_data follows i_data of the owner live while valid.
  always_comb begin
    o_valid = (state_q == S_XFER);
    o_busy  = (state_q != S_IDLE);
    o_owner = owner_q;
    o_err   = err_q;
    o_data  = '0;
    o_done  = '0;
    if (o_valid) begin
      o_data = i_data[owner_q*DATA_W +: DATA_W];
    end
    if (state_q == S_DONE) begin
      o_done = GRANT_ONE << owner_q;
    end
  end

endmodule

// File: tb/tb_arb_xfer_ctrl.sv
// tb_arb_xfer_ctrl
// ----------------
// Self-checking bench for arb_xfer_ctrl. Expected beats and done vectors are
// pushed to queues when a burst is started and popped by a negedge monitor
// whenever the DUT hands over a beat or pulses done.
module tb_arb_xfer_ctrl;

  localparam int N      = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int OW     = $clog2(N);

  logic                clk;
  logic                i_rst;
  logic [N-1:0]        i_grant;
  logic [N*DATA_W-1:0] i_data;
  logic [N*LEN_W-1:0]  i_len;
  logic                i_ready;
  logic [DATA_W-1:0]   o_data;
  logic                o_valid;
  logic [OW-1:0]       o_owner;
  logic                o_busy;
  logic [N-1:0]        o_done;
  logic                o_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] data_tbl [N];
  int                exp_data_q[$];
  int                exp_owner_q[$];
  int                exp_done_q[$];

  bit mon_en       = 1'b0;
  int valid_cycles = 0;
  int accepted     = 0;
  int done_cnt     = 0;
  int err_cnt      = 0;

  arb_xfer_ctrl #(.N(N), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_grant (i_grant),
    .i_data  (i_data),
    .i_len   (i_len),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_owner (o_owner),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop if the sequence ever stalls completely.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] grant, input logic ready);
    i_grant = grant;
    i_ready = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetCounters();
    valid_cycles = 0;
    accepted     = 0;
    done_cnt     = 0;
    err_cnt      = 0;
  endtask

  // Program the requester's length, record the expected beats and done
  // vector, and present its grant (captured at the next rising edge).
  task automatic startBurst(input int r, input int len);
    logic [N-1:0] g;
    i_len[r*LEN_W +: LEN_W] = LEN_W'(len);
    for (int b = 0; b <= len; b++) begin
      exp_data_q.push_back(int'(data_tbl[r]));
      exp_owner_q.push_back(r);
    end
    g    = '0;
    g[r] = 1'b1;
    exp_done_q.push_back(int'(g));
    applyStimulus(g, 1'b1);
  endtask

  // Only records expectations; used when the grant is already being driven.
  task automatic expectBurst(input int r, input int len);
    logic [N-1:0] g;
    i_len[r*LEN_W +: LEN_W] = LEN_W'(len);
    for (int b = 0; b <= len; b++) begin
      exp_data_q.push_back(int'(data_tbl[r]));
      exp_owner_q.push_back(r);
    end
    g    = '0;
    g[r] = 1'b1;
    exp_done_q.push_back(int'(g));
  endtask

  // Bounded wait for o_busy to drop, returns just after the next rising edge.
  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy && n < budget);
    checkOutput(tag, 32'(o_busy), 32'(0));
    tick();
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_valid) begin
        valid_cycles++;
      end else begin
        checkOutput("data_zero_when_invalid", 32'(o_data), 32'(0));
      end
      if (o_valid && i_ready) begin
        accepted++;
        if (exp_data_q.size() == 0) begin
          checkOutput("beat_unexpected", 32'(1), 32'(0));
        end else begin
          checkOutput("beat_data", 32'(o_data), 32'(exp_data_q.pop_front()));
          checkOutput("beat_owner", 32'(o_owner), 32'(exp_owner_q.pop_front()));
        end
      end
      if (o_done != '0) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          checkOutput("done_unexpected", 32'(o_done), 32'(0));
        end else begin
          checkOutput("done_vec", 32'(o_done), 32'(exp_done_q.pop_front()));
        end
      end
      if (o_err) begin
        err_cnt++;
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      data_tbl[k] = DATA_W'(k * 37 + 13);
    end
    for (int k = 0; k < N; k++) begin
      i_data[k*DATA_W +: DATA_W] = data_tbl[k];
    end
    i_len = '0;
    i_rst = 1'b1;
    applyStimulus('0, 1'b0);
    tick();
    tick();
    i_rst  = 1'b0;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_valid", 32'(o_valid), 32'(0));
    checkOutput("rst_data",  32'(o_data),  32'(0));
    checkOutput("rst_owner", 32'(o_owner), 32'(0));
    checkOutput("rst_busy",  32'(o_busy),  32'(0));
    checkOutput("rst_done",  32'(o_done),  32'(0));
    checkOutput("rst_err",   32'(o_err),   32'(0));
    tick();

    // Basic 3-beat burst from requester 2
    resetCounters();
    startBurst(2, 2);
    tick();
    applyStimulus('0, 1'b1);
    @(negedge clk);
    checkOutput("b1_owner", 32'(o_owner), 32'(2));
    checkOutput("b1_busy",  32'(o_busy),  32'(1));
    waitIdle("b1_idle", 20);
    checkOutput("b1_valid_cycles", 32'(valid_cycles), 32'(3));
    checkOutput("b1_accepted",     32'(accepted),     32'(3));
    checkOutput("b1_done_cnt",     32'(done_cnt),     32'(1));

    // Same burst with i_ready low for 2 cycles on the 2nd beat
    resetCounters();
    startBurst(2, 2);
    tick();
    applyStimulus('0, 1'b1);
    tick();
    applyStimulus('0, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick();
    applyStimulus('0, 1'b1);
    waitIdle("b2_idle", 20);
    checkOutput("b2_valid_cycles", 32'(valid_cycles), 32'(5));
    checkOutput("b2_accepted",     32'(accepted),     32'(3));
    checkOutput("b2_done_cnt",     32'(done_cnt),     32'(1));

    // Grant for requester 7 held during requester 0's burst
    resetCounters();
    startBurst(0, 3);
    tick();
    expectBurst(7, 1);
    applyStimulus(8'b1000_0000, 1'b1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("b3_owner_held", 32'(o_owner), 32'(0));
      checkOutput("b3_no_err",     32'(o_err),   32'(0));
    end
    waitIdle("b3_idle0", 20);
    applyStimulus('0, 1'b1);
    @(negedge clk);
    checkOutput("b3_owner7", 32'(o_owner), 32'(7));
    waitIdle("b3_idle7", 20);
    checkOutput("b3_err_cnt",  32'(err_cnt),  32'(0));
    checkOutput("b3_done_cnt", 32'(done_cnt), 32'(2));
    checkOutput("b3_accepted", 32'(accepted), 32'(6));

    // Multi-bit grant in IDLE
    resetCounters();
    applyStimulus(8'b0001_0010, 1'b1);
    tick();
    applyStimulus('0, 1'b1);
    @(negedge clk);
    checkOutput("err_pulse", 32'(o_err),   32'(1));
    checkOutput("err_valid", 32'(o_valid), 32'(0));
    checkOutput("err_owner", 32'(o_owner), 32'(7));
    checkOutput("err_busy",  32'(o_busy),  32'(0));
    tick();
    @(negedge clk);
    checkOutput("err_cleared", 32'(o_err), 32'(0));
    tick();
    checkOutput("err_cnt", 32'(err_cnt), 32'(1));

    // Maximum length burst from requester 5 with random stalls
    resetCounters();
    startBurst(5, 15);
    tick();
    applyStimulus('0, 1'($urandom_range(0, 3) != 0));
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!o_busy) break;
      tick();
      i_ready = ($urandom_range(0, 3) != 0);
    end
    checkOutput("b5_idle", 32'(o_busy), 32'(0));
    tick();
    checkOutput("b5_accepted", 32'(accepted), 32'(16));
    checkOutput("b5_done_cnt", 32'(done_cnt), 32'(1));

    // Reset after 1 of 4 beats of requester 3
    resetCounters();
    startBurst(3, 3);
    tick();
    applyStimulus('0, 1'b1);
    tick();
    i_rst = 1'b1;
    applyStimulus('0, 1'b0);
    tick();
    i_rst = 1'b0;
    applyStimulus('0, 1'b1);
    exp_data_q.delete();
    exp_owner_q.delete();
    exp_done_q.delete();
    @(negedge clk);
    checkOutput("abort_valid", 32'(o_valid), 32'(0));
    checkOutput("abort_data",  32'(o_data),  32'(0));
    checkOutput("abort_owner", 32'(o_owner), 32'(0));
    checkOutput("abort_busy",  32'(o_busy),  32'(0));
    checkOutput("abort_done",  32'(o_done),  32'(0));
    checkOutput("abort_err",   32'(o_err),   32'(0));
    tick();
    checkOutput("abort_accepted", 32'(accepted), 32'(1));
    checkOutput("abort_done_cnt", 32'(done_cnt), 32'(0));

    // Single-beat burst after the abort
    resetCounters();
    startBurst(6, 0);
    tick();
    applyStimulus('0, 1'b1);
    @(negedge clk);
    checkOutput("b6_owner", 32'(o_owner), 32'(6));
    waitIdle("b6_idle", 20);
    checkOutput("b6_accepted", 32'(accepted), 32'(1));
    checkOutput("b6_done_cnt", 32'(done_cnt), 32'(1));

    checkOutput("sb_beats_left", 32'(exp_data_q.size()), 32'(0));
    checkOutput("sb_done_left",  32'(exp_done_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
